// File: rtl/custom_logic_pkg.sv
// Shared job-state encoding and default sizing for the SDRAM frame DMA.
package custom_logic_pkg;

    localparam int DEF_ADDR_W     = 26;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DIM_W      = 13;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_MAX_OUT    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO buffering SDRAM read returns ahead of the pixel filter.
module sync_fifo
    import custom_logic_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             head_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sdram_frame_dma.sv
// Frame DMA: streams a source frame from SDRAM to the filter and writes the
// filtered pixels back to a destination frame.
//
//   state   | meaning
//   IDLE    | waiting for start; job inputs latched on launch
//   RUN     | issuing reads/writes until every transfer has completed
//   DONE    | job finished; held until start is released
module sdram_frame_dma
    import custom_logic_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DIM_W      = DEF_DIM_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MAX_OUT    = DEF_MAX_OUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              crop,
    output logic              sdram_read_en,
    output logic              sdram_write_en,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [DATA_W-1:0] sdram_writedata,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_datareadvalid,
    input  logic              sdram_waitrequest,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              finish_flag
);
    localparam int CW     = 2 * DIM_W;
    localparam int OUT_W  = $clog2(FIFO_DEPTH) + 2;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [OUT_W-1:0] DEPTH_C   = OUT_W'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CW-1:0]     rd_left_q, rd_left_d;
    logic [CW-1:0]     wr_left_q, wr_left_d;
    logic [OUT_W-1:0]  outstanding_q, outstanding_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              lock_q, lock_d;
    logic              lock_wr_q, lock_wr_d;

    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic              run, rd_can, sel_rd, sel_wr, rd_acc, wr_acc;
    logic              wr_fire, ret_ok, job_done, dim_zero;
    logic [CW-1:0]     w_ext, h_ext, rd_total, wr_total;

    assign w_ext    = CW'(img_width);
    assign h_ext    = CW'(img_height);
    assign rd_total = w_ext * h_ext;
    assign wr_total = crop ? (w_ext - CW'(1)) * (h_ext - CW'(1)) : rd_total;
    assign dim_zero = (img_width == '0) || (img_height == '0);

    assign run    = (state_q == ST_RUN);
    assign rd_can = (rd_left_q != '0) && (outstanding_q < MAX_OUT_C) &&
                    ((outstanding_q + OUT_W'(fifo_count)) < DEPTH_C);

    // A stalled command stays locked so a write arriving mid-stall cannot swap it out.
    assign sel_wr = run && (lock_q ? lock_wr_q : hold_valid_q);
    assign sel_rd = run && (lock_q ? ~lock_wr_q : (~hold_valid_q && rd_can));
    assign rd_acc = sel_rd && ~sdram_waitrequest;
    assign wr_acc = sel_wr && ~sdram_waitrequest;

    assign sdram_read_en   = sel_rd;
    assign sdram_write_en  = sel_wr;
    assign sdram_address   = sel_wr ? wr_addr_q : (sel_rd ? rd_addr_q : '0);
    assign sdram_writedata = sel_wr ? hold_data_q : '0;

    assign rd_valid  = ~fifo_empty;
    assign fifo_pop  = rd_valid && rd_ready;
    assign ret_ok    = sdram_datareadvalid && (outstanding_q != '0);
    assign fifo_push = ret_ok && (~fifo_full || fifo_pop);

    assign wr_ready = run && ~hold_valid_q && (wr_left_q != '0);
    assign wr_fire  = wr_valid && wr_ready;

    assign job_done = (rd_left_q == '0) && (outstanding_q == '0) && fifo_empty &&
                      (wr_left_q == '0) && ~hold_valid_q;

    assign busy        = run;
    assign finish_flag = (state_q == ST_DONE);

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        rd_left_d     = rd_left_q;
        wr_left_d     = wr_left_q;
        outstanding_d = outstanding_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        lock_d        = (sel_wr || sel_rd) && sdram_waitrequest;
        lock_wr_d     = sel_wr;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    rd_addr_d = src_addr;
                    wr_addr_d = dst_addr;
                    rd_left_d = dim_zero ? '0 : rd_total;
                    wr_left_d = dim_zero ? '0 : wr_total;
                end
            end
            ST_RUN: begin
                if (rd_acc) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - CW'(1);
                end
                if (wr_acc) begin
                    wr_addr_d    = wr_addr_q + ADDR_W'(1);
                    hold_valid_d = 1'b0;
                end
                if (wr_fire) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = wr_data;
                    wr_left_d    = wr_left_q - CW'(1);
                end
                if (job_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case ({rd_acc, ret_ok})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            rd_left_q     <= '0;
            wr_left_q     <= '0;
            outstanding_q <= '0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
            lock_q        <= 1'b0;
            lock_wr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            rd_left_q     <= rd_left_d;
            wr_left_q     <= wr_left_d;
            outstanding_q <= outstanding_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            lock_q        <= lock_d;
            lock_wr_q     <= lock_wr_d;
        end
    end

    sync_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_rd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(sdram_readdata),
        .pop      (fifo_pop),
        .head_data(rd_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_sdram_frame_dma.sv
// Directed bench for sdram_frame_dma with an SDRAM model and a loopback filter.
module tb_sdram_frame_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] img_width = '0;
    logic [12:0] img_height = '0;
    logic [25:0] src_addr = '0;
    logic [25:0] dst_addr = '0;
    logic        crop = 1'b0;
    logic        sdram_read_en, sdram_write_en;
    logic [25:0] sdram_address;
    logic [31:0] sdram_writedata;
    logic [31:0] sdram_readdata = '0;
    logic        sdram_datareadvalid = 1'b0;
    logic        sdram_waitrequest = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready, busy, finish_flag;

    sdram_frame_dma dut (
        .clk(clk), .rst(rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .src_addr(src_addr), .dst_addr(dst_addr), .crop(crop),
        .sdram_read_en(sdram_read_en), .sdram_write_en(sdram_write_en),
        .sdram_address(sdram_address), .sdram_writedata(sdram_writedata),
        .sdram_readdata(sdram_readdata), .sdram_datareadvalid(sdram_datareadvalid),
        .sdram_waitrequest(sdram_waitrequest),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .finish_flag(finish_flag)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;

    // Environment controls, set by the test tasks.
    int          lat = 2;
    bit          tb_wait = 1'b0;
    bit          rd_all = 1'b0;
    bit          loop_en = 1'b0;
    int          pop_budget = 0;
    bit          man_valid = 1'b0;
    logic [31:0] man_data = '0;

    // Model state and logs.
    int          cyc = 0;
    int          ret_due[$];
    logic [31:0] ret_dat[$];
    logic [25:0] rd_log[$];
    logic [25:0] wa_log[$];
    logic [31:0] wd_log[$];
    logic [31:0] fq[$];
    logic [31:0] popped[$];
    bit          order_log[$];
    int          max_fl = 0;
    int          stall_err = 0;
    int          dual_err = 0;
    int          cmd_seen = 0;
    bit          stall_prev = 1'b0;
    logic        p_rd, p_wr;
    logic [25:0] p_addr;
    logic [31:0] p_data;

    function automatic logic [31:0] mdat(input logic [25:0] a);
        return {6'h34, a};
    endfunction

    // Inputs are driven at the falling edge; handshakes logged here complete at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        sdram_datareadvalid = 1'b0;
        sdram_readdata      = '0;
        if (ret_due.size() > 0 && ret_due[0] == cyc) begin
            sdram_datareadvalid = 1'b1;
            sdram_readdata      = ret_dat[0];
            void'(ret_due.pop_front());
            void'(ret_dat.pop_front());
        end
        sdram_waitrequest = tb_wait;
        rd_ready = rd_all || (pop_budget > 0);
        if (loop_en) begin
            wr_valid = (fq.size() > 0);
            wr_data  = (fq.size() > 0) ? fq[0] : '0;
        end else begin
            wr_valid = man_valid;
            wr_data  = man_data;
        end
        if (stall_prev && (sdram_read_en !== p_rd || sdram_write_en !== p_wr ||
                           sdram_address !== p_addr || sdram_writedata !== p_data))
            stall_err++;
        stall_prev = (sdram_read_en || sdram_write_en) && sdram_waitrequest;
        p_rd = sdram_read_en; p_wr = sdram_write_en;
        p_addr = sdram_address; p_data = sdram_writedata;
        if (sdram_read_en && sdram_write_en) dual_err++;
        if (sdram_read_en || sdram_write_en) cmd_seen++;
        if (sdram_read_en && !sdram_waitrequest) begin
            rd_log.push_back(sdram_address);
            order_log.push_back(1'b0);
            ret_due.push_back(cyc + lat);
            ret_dat.push_back(mdat(sdram_address));
        end
        if (sdram_write_en && !sdram_waitrequest) begin
            wa_log.push_back(sdram_address);
            wd_log.push_back(sdram_writedata);
            order_log.push_back(1'b1);
        end
        if (ret_due.size() > max_fl) max_fl = ret_due.size();
        if (rd_valid && rd_ready) begin
            if (loop_en) fq.push_back(rd_data);
            else popped.push_back(rd_data);
            if (pop_budget > 0) pop_budget--;
        end
        if (wr_valid && wr_ready) begin
            if (loop_en) void'(fq.pop_front());
            else man_valid = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        fq.delete(); popped.delete(); order_log.delete();
        max_fl = 0;
    endtask

    task automatic launch(input logic [12:0] w, input logic [12:0] h,
                          input logic [25:0] s, input logic [25:0] d, input logic c);
        img_width = w; img_height = h; src_addr = s; dst_addr = d; crop = c;
        start = 1'b1;
    endtask

    task automatic wait_finish(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (finish_flag === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic end_job();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        total++; if (sdram_read_en !== 1'b0) $display("FAIL rst_read_en got %b want 0", sdram_read_en); else pass_cnt++;
        total++; if (sdram_write_en !== 1'b0) $display("FAIL rst_write_en got %b want 0", sdram_write_en); else pass_cnt++;
        total++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %b want 0", rd_valid); else pass_cnt++;
        total++; if (wr_ready !== 1'b0) $display("FAIL rst_wr_ready got %b want 0", wr_ready); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
        total++; if (finish_flag !== 1'b0) $display("FAIL rst_finish got %b want 0", finish_flag); else pass_cnt++;
        total++; if (sdram_address !== 26'h0) $display("FAIL rst_address got %h want 0", sdram_address); else pass_cnt++;
        total++; if (sdram_writedata !== 32'h0) $display("FAIL rst_writedata got %h want 0", sdram_writedata); else pass_cnt++;
        rst = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [25:0] ea;
        clear_logs();
        lat = 2; rd_all = 1'b1; loop_en = 1'b1; tb_wait = 1'b0;
        launch(13'd4, 13'd3, 26'h100, 26'h2000, 1'b0);
        wait_finish(500, ok);
        total++; if (!ok) $display("FAIL basic_done timeout got finish=%b want 1", finish_flag); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy); else pass_cnt++;
        total++; if (rd_log.size() != 12) $display("FAIL basic_nreads got %0d want 12", rd_log.size()); else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            ea = 26'h100 + 26'(i);
            total++;
            if (i >= rd_log.size() || rd_log[i] !== ea)
                $display("FAIL basic_raddr[%0d] got %h want %h", i, (i < rd_log.size()) ? rd_log[i] : 26'h0, ea);
            else pass_cnt++;
        end
        total++; if (wa_log.size() != 12) $display("FAIL basic_nwrites got %0d want 12", wa_log.size()); else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            ea = 26'h2000 + 26'(i);
            total++;
            if (i >= wa_log.size() || wa_log[i] !== ea || wd_log[i] !== mdat(26'h100 + 26'(i)))
                $display("FAIL basic_write[%0d] got %h/%h want %h/%h", i,
                         (i < wa_log.size()) ? wa_log[i] : 26'h0, (i < wd_log.size()) ? wd_log[i] : 32'h0,
                         ea, mdat(26'h100 + 26'(i)));
            else pass_cnt++;
        end
        end_job();
        total++; if (finish_flag !== 1'b0) $display("FAIL basic_release got finish=%b want 0", finish_flag); else pass_cnt++;
    endtask

    task automatic test_crop();
        bit ok;
        clear_logs();
        lat = 2; rd_all = 1'b1; loop_en = 1'b1;
        launch(13'd4, 13'd3, 26'h100, 26'h3000, 1'b1);
        wait_finish(500, ok);
        total++; if (!ok) $display("FAIL crop_done timeout got finish=%b want 1", finish_flag); else pass_cnt++;
        total++; if (rd_log.size() != 12) $display("FAIL crop_nreads got %0d want 12", rd_log.size()); else pass_cnt++;
        total++; if (wa_log.size() != 6) $display("FAIL crop_nwrites got %0d want 6", wa_log.size()); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= wa_log.size() || wa_log[i] !== 26'h3000 + 26'(i) || wd_log[i] !== mdat(26'h100 + 26'(i)))
                $display("FAIL crop_write[%0d] got %h/%h want %h/%h", i,
                         (i < wa_log.size()) ? wa_log[i] : 26'h0, (i < wd_log.size()) ? wd_log[i] : 32'h0,
                         26'h3000 + 26'(i), mdat(26'h100 + 26'(i)));
            else pass_cnt++;
        end
        total++; if (fq.size() != 6) $display("FAIL crop_unaccepted got %0d want 6", fq.size()); else pass_cnt++;
        total++; if (wr_valid !== 1'b1 || wr_ready !== 1'b0)
            $display("FAIL crop_7th_wr got valid=%b ready=%b want valid=1 ready=0", wr_valid, wr_ready);
        else pass_cnt++;
        end_job();
        fq.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        lat = 10; rd_all = 1'b0; loop_en = 1'b1;
        launch(13'd4, 13'd4, 26'h400, 26'h800, 1'b0);
        repeat (50) tick();
        total++; if (max_fl > 4) $display("FAIL bp_in_flight got %0d want <=4", max_fl); else pass_cnt++;
        total++; if (rd_log.size() > 8 || rd_log.size() == 0) $display("FAIL bp_reads got %0d want 1..8", rd_log.size()); else pass_cnt++;
        total++; if (rd_valid !== 1'b1) $display("FAIL bp_rd_valid got %b want 1", rd_valid); else pass_cnt++;
        rd_all = 1'b1;
        wait_finish(1000, ok);
        total++; if (!ok) $display("FAIL bp_done timeout got finish=%b want 1", finish_flag); else pass_cnt++;
        total++; if (wa_log.size() != 16) $display("FAIL bp_nwrites got %0d want 16", wa_log.size()); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= wd_log.size() || wd_log[i] !== mdat(26'h400 + 26'(i)) || wa_log[i] !== 26'h800 + 26'(i))
                $display("FAIL bp_write[%0d] got %h want %h", i,
                         (i < wd_log.size()) ? wd_log[i] : 32'h0, mdat(26'h400 + 26'(i)));
            else pass_cnt++;
        end
        total++; if (max_fl > 4) $display("FAIL bp_in_flight_end got %0d want <=4", max_fl); else pass_cnt++;
        end_job();
    endtask

    task automatic test_back_to_back_stall();
        bit ok;
        bit reached;
        clear_logs();
        lat = 2; rd_all = 1'b0; loop_en = 1'b0; pop_budget = 0;
        launch(13'd16, 13'd1, 26'h200, 26'h300, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rd_log.size() == 8 && ret_due.size() == 0 && rd_valid === 1'b1) begin
                reached = 1'b1;
                break;
            end
        end
        total++; if (!reached) $display("FAIL stall_fill timeout got reads=%0d want 8", rd_log.size()); else pass_cnt++;
        tick(); tick();
        total++; if (rd_log.size() != 8) $display("FAIL stall_credit got %0d want 8", rd_log.size()); else pass_cnt++;
        tb_wait = 1'b1;
        man_data = 32'hCAFE_0001;
        man_valid = 1'b1;
        tick(); tick(); tick();
        pop_budget = 1;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (sdram_write_en !== 1'b1 || sdram_read_en !== 1'b0 ||
                sdram_address !== 26'h300 || sdram_writedata !== 32'hCAFE_0001)
                $display("FAIL stall_hold[%0d] got wr=%b rd=%b addr=%h data=%h want wr=1 rd=0 addr=300 data=cafe0001",
                         i, sdram_write_en, sdram_read_en, sdram_address, sdram_writedata);
            else pass_cnt++;
        end
        order_log.delete();
        tb_wait = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (order_log.size() >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        total++; if (!reached) $display("FAIL stall_release timeout got %0d accepts want 2", order_log.size()); else pass_cnt++;
        total++;
        if (order_log.size() < 2 || order_log[0] !== 1'b1 || wa_log.size() != 1 || wa_log[0] !== 26'h300)
            $display("FAIL stall_first got kind=%b writes=%0d want write to 300",
                     (order_log.size() > 0) ? order_log[0] : 1'b0, wa_log.size());
        else pass_cnt++;
        total++;
        if (order_log.size() < 2 || order_log[1] !== 1'b0 || rd_log.size() != 9 || rd_log[8] !== 26'h208)
            $display("FAIL stall_second got kind=%b reads=%0d want read of 208",
                     (order_log.size() > 1) ? order_log[1] : 1'b1, rd_log.size());
        else pass_cnt++;
        loop_en = 1'b1; rd_all = 1'b1;
        wait_finish(1000, ok);
        total++; if (!ok) $display("FAIL stall_done timeout got finish=%b want 1", finish_flag); else pass_cnt++;
        total++; if (wa_log.size() != 16) $display("FAIL stall_nwrites got %0d want 16", wa_log.size()); else pass_cnt++;
        total++; if (stall_err != 0) $display("FAIL cmd_stable got %0d violations want 0", stall_err); else pass_cnt++;
        total++; if (dual_err != 0) $display("FAIL one_strobe got %0d violations want 0", dual_err); else pass_cnt++;
        end_job();
        fq.delete();
    endtask

    task automatic test_wrap();
        bit ok;
        logic [25:0] er[4];
        logic [25:0] ew[4];
        er[0] = 26'h3FFFFFE; er[1] = 26'h3FFFFFF; er[2] = 26'h0; er[3] = 26'h1;
        ew[0] = 26'h3FFFFFF; ew[1] = 26'h0; ew[2] = 26'h1; ew[3] = 26'h2;
        clear_logs();
        lat = 2; rd_all = 1'b1; loop_en = 1'b1;
        launch(13'd4, 13'd1, 26'h3FFFFFE, 26'h3FFFFFF, 1'b0);
        wait_finish(300, ok);
        total++; if (!ok) $display("FAIL wrap_done timeout got finish=%b want 1", finish_flag); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= rd_log.size() || rd_log[i] !== er[i])
                $display("FAIL wrap_raddr[%0d] got %h want %h", i, (i < rd_log.size()) ? rd_log[i] : 26'h0, er[i]);
            else pass_cnt++;
            total++;
            if (i >= wa_log.size() || wa_log[i] !== ew[i])
                $display("FAIL wrap_waddr[%0d] got %h want %h", i, (i < wa_log.size()) ? wa_log[i] : 26'h0, ew[i]);
            else pass_cnt++;
        end
        end_job();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit reached;
        int bad;
        clear_logs();
        lat = 10; rd_all = 1'b1; loop_en = 1'b0;
        launch(13'd4, 13'd4, 26'h500, 26'h600, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ret_due.size() == 3) begin
                reached = 1'b1;
                break;
            end
        end
        total++; if (!reached) $display("FAIL rstmid_inflight timeout got %0d want 3", ret_due.size()); else pass_cnt++;
        @(posedge clk);
        #2;
        start = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({sdram_read_en, sdram_write_en, rd_valid, wr_ready, busy, finish_flag} !== 6'b0 ||
            sdram_address !== 26'h0 || sdram_writedata !== 32'h0)
            $display("FAIL rstmid_outputs got rd=%b wr=%b rv=%b wrdy=%b busy=%b fin=%b addr=%h data=%h want all 0",
                     sdram_read_en, sdram_write_en, rd_valid, wr_ready, busy, finish_flag,
                     sdram_address, sdram_writedata);
        else pass_cnt++;
        tick(); tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rd_valid !== 1'b0 || busy !== 1'b0 || finish_flag !== 1'b0) bad++;
        end
        total++; if (bad != 0) $display("FAIL rstmid_late_returns got %0d bad cycles want 0", bad); else pass_cnt++;
        total++; if (ret_due.size() != 0) $display("FAIL rstmid_returns_sent got %0d pending want 0", ret_due.size()); else pass_cnt++;

        clear_logs();
        cmd_seen = 0;
        launch(13'd0, 13'd5, 26'h700, 26'h900, 1'b0);
        tick();
        total++; if (busy !== 1'b1) $display("FAIL zero_run got busy=%b want 1", busy); else pass_cnt++;
        wait_finish(20, ok);
        total++; if (!ok) $display("FAIL zero_done timeout got finish=%b want 1", finish_flag); else pass_cnt++;
        total++; if (cmd_seen != 0) $display("FAIL zero_no_cmd got %0d commands want 0", cmd_seen); else pass_cnt++;
        end_job();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_crop();
        test_backpressure();
        test_back_to_back_stall();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
